pong_score_keeper: RTL and testbench

PONG_SCORE_KEEPER -- requirements
Module: pong_score_keeper

---
 rtl/pong_score_keeper_if.sv | 26 ++
 rtl/pong_score_keeper.sv | 130 +++++++++++++
 tb/tb_pong_score_keeper.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_score_keeper_if.sv
// Bundles the game-control inputs and the score/status outputs of the score keeper.
// Ports: start, p1_point, p2_point (levels into the keeper); p1_score, p2_score,
//        ball_en, point, game_over, winner (registered status out of the keeper).
interface pong_score_keeper_if;
   logic       start;
   logic       p1_point;
   logic       p2_point;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic       ball_en;
   logic       point;
   logic       game_over;
   logic       winner;

   // master drives the button/ball levels and observes the status
   modport master (
      output start, p1_point, p2_point,
      input  p1_score, p2_score, ball_en, point, game_over, winner
   );

   // slave is the score keeper itself
   modport slave (
      input  start, p1_point, p2_point,
      output p1_score, p2_score, ball_en, point, game_over, winner
   );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong score keeper: edge-detects start/point levels, keeps both scores, runs the
// IDLE/PLAY/HOLDOFF/OVER game flow. Outputs registered, one-cycle latency from edge.
// Ports: i_CLK, i_RST (sync active-high), bus (slave side of pong_score_keeper_if).
module pong_score_keeper #(
   parameter int WIN_SCORE      = 9,
   parameter int HOLDOFF_CYCLES = 50000000
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   pong_score_keeper_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, PLAY, HOLDOFF, OVER} state_t;

   localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
   localparam logic [25:0] HOLD_LOAD = 26'(HOLDOFF_CYCLES - 1);

   state_t      state, state_n;
   logic [25:0] cnt, cnt_n;
   logic        prev_start, prev_p1, prev_p2;
   logic        start_edge, p1_edge, p2_edge;

   logic [3:0]  p1_q, p2_q, p1_n, p2_n;
   logic [3:0]  p1_inc, p2_inc;
   logic        ball_q, point_q, over_q, winner_q;
   logic        ball_n, point_n, over_n, winner_n;

   assign start_edge = bus.start    & ~prev_start;
   assign p1_edge    = bus.p1_point & ~prev_p1;
   assign p2_edge    = bus.p2_point & ~prev_p2;
   assign p1_inc     = p1_q + 4'd1;
   assign p2_inc     = p2_q + 4'd1;

   // State register: FSM state, hold-off counter, edge history and all outputs
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state      <= IDLE;
         cnt        <= '0;
         prev_start <= 1'b0;
         prev_p1    <= 1'b0;
         prev_p2    <= 1'b0;
         p1_q       <= '0;
         p2_q       <= '0;
         ball_q     <= 1'b0;
         point_q    <= 1'b0;
         over_q     <= 1'b0;
         winner_q   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         prev_start <= bus.start;
         prev_p1    <= bus.p1_point;
         prev_p2    <= bus.p2_point;
         p1_q       <= p1_n;
         p2_q       <= p2_n;
         ball_q     <= ball_n;
         point_q    <= point_n;
         over_q     <= over_n;
         winner_q   <= winner_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start_edge) state_n = PLAY;
         PLAY: begin
            if (p1_edge && p2_edge)
               state_n = HOLDOFF;             // simultaneous points: rally replayed
            else if (p1_edge)
               state_n = (p1_inc == WIN) ? OVER : HOLDOFF;
            else if (p2_edge)
               state_n = (p2_inc == WIN) ? OVER : HOLDOFF;
         end
         HOLDOFF: if (cnt == '0) state_n = PLAY;
         OVER:    if (start_edge) state_n = PLAY;
      endcase
   end

   // Output logic: next values of the registered outputs and the counter
   always_comb begin
      cnt_n    = cnt;
      p1_n     = p1_q;
      p2_n     = p2_q;
      winner_n = winner_q;
      point_n  = 1'b0;
      unique case (state)
         IDLE: begin
            p1_n     = '0;
            p2_n     = '0;
            winner_n = 1'b0;
         end
         PLAY: begin
            if (p1_edge || p2_edge)
               cnt_n = HOLD_LOAD;
            if (p1_edge && !p2_edge) begin
               p1_n    = p1_inc;
               point_n = 1'b1;
               if (p1_inc == WIN) winner_n = 1'b0;
            end else if (p2_edge && !p1_edge) begin
               p2_n    = p2_inc;
               point_n = 1'b1;
               if (p2_inc == WIN) winner_n = 1'b1;
            end
         end
         HOLDOFF: begin
            if (cnt != '0) cnt_n = cnt - 26'd1;
         end
         OVER: begin
            if (start_edge) begin
               p1_n     = '0;
               p2_n     = '0;
               winner_n = 1'b0;
            end
         end
      endcase
      // ball and game-over flags follow the state being entered so they line up with it
      ball_n = (state_n == PLAY);
      over_n = (state_n == OVER);
   end

   assign bus.p1_score  = p1_q;
   assign bus.p2_score  = p2_q;
   assign bus.ball_en   = ball_q;
   assign bus.point     = point_q;
   assign bus.game_over = over_q;
   assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Testbench for pong_score_keeper with WIN_SCORE=3, HOLDOFF_CYCLES=4: directed
// scenarios plus randomized levels, all checked against a game-rule reference model.
// Ports: none (top-level bench).
module tb_pong_score_keeper;
   localparam int W = 3;
   localparam int H = 4;

   logic i_CLK = 1'b0;
   logic i_RST = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pong_score_keeper_if bus ();

   pong_score_keeper #(.WIN_SCORE(W), .HOLDOFF_CYCLES(H)) dut (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .bus   (bus)
   );

   always #5 i_CLK = ~i_CLK;

   logic [11:0] obs;
   assign obs = {bus.p1_score, bus.p2_score, bus.ball_en, bus.point, bus.game_over, bus.winner};

   // Reference model: game phase, remaining blank-ball cycles, scores
   // phase: 0 = waiting for start, 1 = ball in play, 2 = serve delay, 3 = game finished
   int m_phase = 0, m_blank = 0, m_p1 = 0, m_p2 = 0;
   bit m_point = 0, m_win = 0;
   bit h_start = 0, h_p1 = 0, h_p2 = 0;

   function automatic logic [11:0] exp_vec();
      return {4'(m_p1), 4'(m_p2), (m_phase == 1), m_point, (m_phase == 3), m_win};
   endfunction

   task automatic model_step();
      bit se, e1, e2;
      se = bus.start & !h_start;
      e1 = bus.p1_point & !h_p1;
      e2 = bus.p2_point & !h_p2;
      m_point = 0;
      if (i_RST) begin
         m_phase = 0; m_blank = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
         h_start = 0; h_p1 = 0; h_p2 = 0;
         return;
      end
      case (m_phase)
         0: if (se) m_phase = 1;
         1: begin
            if (e1 && e2) begin
               m_phase = 2; m_blank = H;
            end else if (e1 || e2) begin
               m_point = 1;
               if (e1) m_p1++; else m_p2++;
               if (m_p1 == W || m_p2 == W) begin
                  m_phase = 3; m_win = e2;
               end else begin
                  m_phase = 2; m_blank = H;
               end
            end
         end
         2: begin
            m_blank--;
            if (m_blank == 0) m_phase = 1;
         end
         default: if (se) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_phase = 1;
         end
      endcase
      h_start = bus.start; h_p1 = bus.p1_point; h_p2 = bus.p2_point;
   endtask

   // Advance one clock: model consumes the current inputs, DUT samples them at the edge
   task automatic tick();
      model_step();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic test_reset();
      bus.start = 0; bus.p1_point = 0; bus.p2_point = 0;
      i_RST = 1;
      tick(); tick();
      checks++;
      if (obs !== 12'h000) begin
         errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
      end
      i_RST = 0;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_start();
      // point edges in IDLE are ignored
      bus.p1_point = 1; tick(); bus.p1_point = 0; tick();
      checks++;
      if (obs !== 12'h000) begin
         errors++; $display("FAIL idle_point_ignored: got %h expected %h", obs, 12'h000);
      end
      bus.start = 1; tick(); bus.start = 0;
      checks++;
      if (obs !== 12'b0000_0000_1000 || obs !== exp_vec()) begin
         errors++; $display("FAIL start_play: got %h expected %h", obs, 12'b0000_0000_1000);
      end
   endtask

   task automatic test_hold_high();
      int pts = 0, low = 0;
      bus.p1_point = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL hold_high_model: got %h expected %h", obs, exp_vec());
         end
         if (bus.point) pts++;
         if (!bus.ball_en) low++;
      end
      bus.p1_point = 0;
      tick();
      checks++;
      if (pts != 1 || low != H || bus.p1_score !== 4'd1 || bus.ball_en !== 1'b1) begin
         errors++;
         $display("FAIL hold_high_once: got pts=%0d low=%0d p1=%0d ball=%b expected pts=1 low=%0d p1=1 ball=1",
                  pts, low, bus.p1_score, bus.ball_en, H);
      end
   endtask

   task automatic test_tie();
      bus.p1_point = 1; bus.p2_point = 1;
      tick();
      bus.p1_point = 0; bus.p2_point = 0;
      checks++;
      if (obs !== 12'b0001_0000_0000 || obs !== exp_vec()) begin
         errors++; $display("FAIL tie_no_point: got %h expected %h", obs, 12'b0001_0000_0000);
      end
      for (int i = 0; i < H; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL tie_holdoff: got %h expected %h", obs, exp_vec());
         end
      end
   endtask

   task automatic test_p2_win();
      for (int n = 0; n < 3; n++) begin
         bus.p2_point = 1; tick(); bus.p2_point = 0;
         checks++;
         if (bus.point !== 1'b1 || obs !== exp_vec()) begin
            errors++; $display("FAIL p2_point_pulse: got %h expected %h", obs, exp_vec());
         end
         for (int i = 0; i < H; i++) tick();
      end
      checks++;
      if (obs !== 12'b0001_0011_0011 || obs !== exp_vec()) begin
         errors++; $display("FAIL p2_wins: got %h expected %h", obs, 12'b0001_0011_0011);
      end
      bus.p1_point = 1; tick(); bus.p1_point = 0; bus.p2_point = 1; tick(); bus.p2_point = 0; tick();
      checks++;
      if (obs !== 12'b0001_0011_0011) begin
         errors++; $display("FAIL over_frozen: got %h expected %h", obs, 12'b0001_0011_0011);
      end
      bus.start = 1; tick(); bus.start = 0;
      checks++;
      if (obs !== 12'b0000_0000_1000 || obs !== exp_vec()) begin
         errors++; $display("FAIL over_restart: got %h expected %h", obs, 12'b0000_0000_1000);
      end
   endtask

   task automatic score_one(input bit p2);
      if (p2) bus.p2_point = 1; else bus.p1_point = 1;
      tick();
      bus.p1_point = 0; bus.p2_point = 0;
      for (int i = 0; i < H; i++) tick();
   endtask

   task automatic test_start_in_play();
      score_one(0); score_one(0); score_one(1);
      checks++;
      if (obs !== 12'b0010_0001_1000 || obs !== exp_vec()) begin
         errors++; $display("FAIL score_2_1: got %h expected %h", obs, 12'b0010_0001_1000);
      end
      bus.start = 1; tick(); bus.start = 0; tick();
      checks++;
      if (obs !== 12'b0010_0001_1000) begin
         errors++; $display("FAIL start_in_play: got %h expected %h", obs, 12'b0010_0001_1000);
      end
   endtask

   task automatic test_rst_holdoff();
      bus.p1_point = 1; bus.p2_point = 1; tick();
      bus.p1_point = 0; bus.p2_point = 0; tick(); tick();
      checks++;
      if (obs !== 12'b0010_0001_0000) begin
         errors++; $display("FAIL mid_holdoff: got %h expected %h", obs, 12'b0010_0001_0000);
      end
      i_RST = 1; tick(); i_RST = 0;
      checks++;
      if (obs !== 12'h000 || obs !== exp_vec()) begin
         errors++; $display("FAIL rst_holdoff: got %h expected %h", obs, 12'h000);
      end
      // holdoff must not resume after reset release
      for (int i = 0; i < H + 2; i++) tick();
      checks++;
      if (obs !== 12'h000) begin
         errors++; $display("FAIL rst_stays_idle: got %h expected %h", obs, 12'h000);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         i_RST        = ($urandom_range(0, 199) == 0);
         bus.start    = ($urandom_range(0, 15) == 0);
         bus.p1_point = ($urandom_range(0, 3) == 0);
         bus.p2_point = ($urandom_range(0, 3) == 0);
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_vec());
         end
      end
      i_RST = 0; bus.start = 0; bus.p1_point = 0; bus.p2_point = 0;
   endtask

   initial begin
      bus.start = 0; bus.p1_point = 0; bus.p2_point = 0;
      test_reset();
      test_start();
      test_hold_high();
      test_tie();
      test_p2_win();
      test_start_in_play();
      test_rst_holdoff();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
